// File: rtl/wt_inval_queue.sv
// wt_inval_queue: line-aligned snoop invalidation FIFO feeding the write-through
// cache subsystem's invalidation port, with optional tail coalescing.
//
// Build option: define WT_INVAL_MERGE_EN to coalesce a request into the tail entry
// when both fall on the same line. Without it, every accepted request takes an entry.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   snoop_valid_i/_o    request from interconnect; snoop_ready_o accepts it
//   snoop_addr_i        byte address; the line-offset bits are cleared on entry
//   inval_valid_o       head entry valid toward the cache subsystem
//   inval_ready_i       cache subsystem takes the head
//   inval_addr_o        line address of the head (holds last value when empty)
//   count_o             occupied entries
//   merged_o            one-cycle pulse after a request was coalesced
module wt_inval_queue #(
    parameter int unsigned Depth       = 4,
    parameter int unsigned OffsetWidth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     snoop_valid_i,
    output logic                     snoop_ready_o,
    input  logic [63:0]              snoop_addr_i,
    output logic                     inval_valid_o,
    input  logic                     inval_ready_i,
    output logic [63:0]              inval_addr_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     merged_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [63:0] LineMask = ~((64'd1 << OffsetWidth) - 64'd1);

    logic [63:0]     mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [63:0]     head_q, head_d;
    logic            merged_q, merged_d;

    logic [63:0]     addr_line;
    logic            deq;
    logic            enq;
    logic            merge_hit;

    // Masking rather than slicing keeps every address bit in use.
    assign addr_line = snoop_addr_i & LineMask;
    assign deq       = (count_q != '0) && inval_ready_i;

`ifdef WT_INVAL_MERGE_EN
    logic [PtrW-1:0] tail_ptr;

    // Tail is the slot just behind the write pointer; a lone tail that is leaving
    // this cycle cannot absorb the request.
    assign tail_ptr  = wr_ptr_q - PtrW'(1);
    assign merge_hit = (count_q != '0)
                    && (addr_line == mem_q[tail_ptr])
                    && !((count_q == CntW'(1)) && deq);
`else
    assign merge_hit = 1'b0;
`endif

    // Full refuses non-merging requests even if the head leaves this cycle.
    assign snoop_ready_o = (count_q != CntW'(Depth)) || merge_hit;
    assign enq           = snoop_valid_i && snoop_ready_o && !merge_hit;

    // Next-state for pointers, occupancy, registered head and merge pulse.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        merged_d = snoop_valid_i && merge_hit;

        if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);

        case ({enq, deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // The new head is either the entry being written now or one already stored.
        if (count_d != '0) begin
            if (enq && (wr_ptr_q == rd_ptr_d)) head_d = addr_line;
            else                               head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            merged_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            merged_q <= merged_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= addr_line;
    end

    assign inval_valid_o = (count_q != '0);
    assign inval_addr_o  = head_q;
    assign count_o       = count_q;
    assign merged_o      = merged_q;

endmodule

// File: tb/tb_wt_inval_queue.sv
// Randomized and directed bench for wt_inval_queue against a queue-based model.
module tb_wt_inval_queue;

    localparam int unsigned Depth = 4;
`ifdef WT_INVAL_MERGE_EN
    localparam bit MergeEn = 1'b1;
`else
    localparam bit MergeEn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        snoop_valid_i = 1'b0;
    logic        snoop_ready_o;
    logic [63:0] snoop_addr_i = '0;
    logic        inval_valid_o;
    logic        inval_ready_i = 1'b0;
    logic [63:0] inval_addr_o;
    logic [2:0]  count_o;
    logic        merged_o;

    int checks = 0;
    int failures = 0;

    // Reference state: FIFO contents as a plain queue.
    logic [63:0] mq[$];
    logic [63:0] exp_head = '0;
    logic        exp_merged = 1'b0;

    wt_inval_queue #(.Depth(Depth), .OffsetWidth(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .snoop_valid_i(snoop_valid_i),
        .snoop_ready_o(snoop_ready_o),
        .snoop_addr_i (snoop_addr_i),
        .inval_valid_o(inval_valid_o),
        .inval_ready_i(inval_ready_i),
        .inval_addr_o (inval_addr_o),
        .count_o      (count_o),
        .merged_o     (merged_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("count", 64'(count_o), 64'(mq.size()));
        check_eq("valid", 64'(inval_valid_o), 64'(mq.size() != 0));
        check_eq("addr", inval_addr_o, exp_head);
        check_eq("merged", 64'(merged_o), 64'(exp_merged));
    endtask

    // One clock: drive inputs, check the combinational ready, advance model, check outputs.
    task automatic cycle(input logic v, input logic [63:0] a, input logic r);
        logic [63:0] line;
        logic        deq, merge, rdy, acc;
        snoop_valid_i = v;
        snoop_addr_i  = a;
        inval_ready_i = r;
        #1;
        line  = {a[63:4], 4'h0};
        deq   = (mq.size() != 0) && r;
        merge = MergeEn && (mq.size() != 0) && (line == mq[$]) && !((mq.size() == 1) && deq);
        rdy   = (mq.size() != Depth) || merge;
        acc   = v && rdy;
        check_eq("ready", 64'(snoop_ready_o), 64'(rdy));
        if (deq) void'(mq.pop_front());
        if (acc && !merge) mq.push_back(line);
        exp_merged = acc && merge;
        if (mq.size() != 0) exp_head = mq[0];
        @(posedge clk_i);
        #1;
        check_outputs();
    endtask

    initial begin
        // Power-on reset and reset-state checks.
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(posedge clk_i); #1;
        check_outputs();
        check_eq("rst_ready", 64'(snoop_ready_o), 64'd1);

        // Single snoop drains immediately.
        cycle(1'b1, 64'h8000_1234, 1'b1);
        check_eq("first_addr", inval_addr_o, 64'h8000_1230);
        cycle(1'b0, 64'h0, 1'b1);
        check_eq("drained", 64'(count_o), 64'd0);

        // Fill with ready low, refuse 0x500, then drain in order.
        cycle(1'b1, 64'h100, 1'b0);
        cycle(1'b1, 64'h200, 1'b0);
        cycle(1'b1, 64'h300, 1'b0);
        cycle(1'b1, 64'h400, 1'b0);
        cycle(1'b1, 64'h500, 1'b0);
        cycle(1'b1, 64'h404, 1'b0);      // merge into full tail when enabled
        cycle(1'b1, 64'h500, 1'b1);      // full + dequeue: still refused
        cycle(1'b1, 64'h500, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 64'h0, 1'b1);

        // Same-line burst.
        cycle(1'b1, 64'h1000, 1'b0);
        cycle(1'b1, 64'h1008, 1'b0);
        cycle(1'b1, 64'h100C, 1'b0);
        check_eq("burst_count", 64'(count_o), MergeEn ? 64'd1 : 64'd3);
        for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b1);

        // Lone entry leaving while the same line arrives: enqueued, not merged.
        cycle(1'b1, 64'h2000, 1'b0);
        cycle(1'b1, 64'h2000, 1'b1);
        check_eq("lone_count", 64'(count_o), 64'd1);
        check_eq("lone_addr", inval_addr_o, 64'h2000);
        cycle(1'b0, 64'h0, 1'b1);

        // Asynchronous reset with three entries queued and a request in flight.
        cycle(1'b1, 64'h3000, 1'b0);
        cycle(1'b1, 64'h3100, 1'b0);
        cycle(1'b1, 64'h3200, 1'b0);
        snoop_valid_i = 1'b1;
        snoop_addr_i  = 64'h3300;
        #2 rst_i = 1'b1;
        #1;
        check_eq("async_valid", 64'(inval_valid_o), 64'd0);
        check_eq("async_count", 64'(count_o), 64'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        mq.delete();
        exp_head   = '0;
        exp_merged = 1'b0;
        snoop_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check_outputs();
        cycle(1'b1, 64'h4444, 1'b0);
        check_eq("post_rst_head", inval_addr_o, 64'h4440);

        // Randomized traffic over a few nearby lines to provoke merges and fullness.
        for (int i = 0; i < 400; i++) begin
            logic [63:0] a;
            a = 64'h5000 + 64'($urandom_range(0, 3) * 16) + 64'($urandom_range(0, 15));
            cycle(($urandom_range(0, 9) < 7), a, ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
